// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, bit order g..a.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_GUARD = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the pattern for hex digit n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] seg_s;

  // Table lookup of the segment pattern.
  always_comb begin
    seg_s = seg_lookup(nibble);
  end

  assign seg = seg_s;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with guard
// intervals and frame-boundary double buffering. Optional macro SEG_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [15:0]           value,
  input  logic [3:0]            dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [7:0]            segment,
  output logic [1:0]            digit_idx,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  scan_state_t      state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s;
  logic [1:0]       digit_r, digit_next_s;
  logic             frame_start_s, frame_end_s;

  logic [15:0] act_value_r, act_value_next_s;
  logic [3:0]  act_dp_r, act_dp_next_s;
  logic [15:0] pend_value_r, pend_value_next_s;
  logic [3:0]  pend_dp_r, pend_dp_next_s;
  logic        pending_r, pending_next_s;

  logic [NUM_DIGITS-1:0] anode_r, anode_next_s;
  logic [7:0]            segment_r, segment_next_s;
  logic                  frame_done_r;

  logic [3:0] nibble_s;
  logic [6:0] hex_seg_s;
  logic       blank_s;

  // Scan sequencing: next state, next digit and frame boundary events.
  always_comb begin
    state_next_s  = state_r;
    digit_next_s  = digit_r;
    cnt_clr_s     = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_next_s  = ST_ON;
          digit_next_s  = 2'd0;
          frame_start_s = 1'b1;
          cnt_clr_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ON: begin
        if (cnt_r == DWELL_LAST) begin
          state_next_s = ST_GUARD;
          cnt_clr_s    = 1'b1;
        end else begin
          state_next_s = ST_ON;
        end
      end
      ST_GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          cnt_clr_s = 1'b1;
          if (digit_r != 2'd3) begin
            state_next_s = ST_ON;
            digit_next_s = digit_r + 2'd1;
          end else begin
            frame_end_s = 1'b1;
            if (en) begin
              state_next_s  = ST_ON;
              digit_next_s  = 2'd0;
              frame_start_s = 1'b1;
            end else begin
              state_next_s = ST_IDLE;
            end
          end
        end else begin
          state_next_s = ST_GUARD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        digit_next_s = 2'd0;
        cnt_clr_s    = 1'b1;
      end
    endcase
  end

  // Double buffer: a load on a frame start goes straight to the active copy.
  always_comb begin
    act_value_next_s  = act_value_r;
    act_dp_next_s     = act_dp_r;
    pend_value_next_s = pend_value_r;
    pend_dp_next_s    = pend_dp_r;
    pending_next_s    = pending_r;
    if (frame_start_s) begin
      pending_next_s = 1'b0;
      if (load) begin
        act_value_next_s = value;
        act_dp_next_s    = dp;
      end else if (pending_r) begin
        act_value_next_s = pend_value_r;
        act_dp_next_s    = pend_dp_r;
      end else begin
        act_value_next_s = act_value_r;
      end
    end else if (load) begin
      pend_value_next_s = value;
      pend_dp_next_s    = dp;
      pending_next_s    = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end
  end

  assign nibble_s = act_value_next_s[{digit_next_s, 2'b00} +: 4];

  seg_hex_decode u_hex_decode (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Leading-zero blanking of digits 3..1 when enabled at build time.
  always_comb begin
    blank_s = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    case (digit_next_s)
      2'd3:    blank_s = (act_value_next_s[15:12] == 4'h0);
      2'd2:    blank_s = (act_value_next_s[15:8] == 8'h00);
      2'd1:    blank_s = (act_value_next_s[15:4] == 12'h000);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
  end

  // Pin values for the upcoming cycle, registered below to stay glitch-free.
  always_comb begin
    anode_next_s   = ANODE_OFF;
    segment_next_s = SEG_OFF;
    if (state_next_s == ST_ON) begin
      anode_next_s          = ~(4'b0001 << digit_next_s);
      segment_next_s[7]     = ~act_dp_next_s[digit_next_s];
      segment_next_s[6:0]   = blank_s ? SEG_BLANK : hex_seg_s;
    end else begin
      anode_next_s   = ANODE_OFF;
      segment_next_s = SEG_OFF;
    end
  end

  // Dwell/guard counter, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (cnt_clr_s || (state_r == ST_IDLE)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      digit_r      <= 2'd0;
      act_value_r  <= 16'h0000;
      act_dp_r     <= 4'h0;
      pend_value_r <= 16'h0000;
      pend_dp_r    <= 4'h0;
      pending_r    <= 1'b0;
      anode_r      <= ANODE_OFF;
      segment_r    <= SEG_OFF;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      digit_r      <= digit_next_s;
      act_value_r  <= act_value_next_s;
      act_dp_r     <= act_dp_next_s;
      pend_value_r <= pend_value_next_s;
      pend_dp_r    <= pend_dp_next_s;
      pending_r    <= pending_next_s;
      anode_r      <= anode_next_s;
      segment_r    <= segment_next_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign anode      = anode_r;
  assign segment    = segment_r;
  assign digit_idx  = digit_r;
  assign frame_done = frame_done_r;
  assign pending    = pending_r;

endmodule
